// File: rtl/uart_pkg.sv
// Shared UART types and constants: frame states, parity encodings, legal DATA_W range.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GAP    = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned DATA_W_MAX = 9;

  // Encoding 2'b11 is treated as no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..div_i, tick_c_o on the last count, synchronous clear.
module uart_baud_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_c_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear_i || tick_c_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter on a baud-tick enable with valid/ready input.
// Optional TX FIFO ahead of the frame FSM when UART_TX_FIFO_EN is defined.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned GAP_BITS   = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uart_tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam int unsigned BIT_W = 8;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_data_w
    $error("uart_tx_core: DATA_W out of range");
  end
  if (GAP_BITS > 255) begin : g_bad_gap
    $error("uart_tx_core: GAP_BITS out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_core: FIFO_DEPTH must be a power of two");
  end

  uart_state_e       state_q, state_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] data_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        par_q;
  logic              two_q;
  logic              tick_c;
  logic              start_c;
  logic [DATA_W-1:0] word_c;
  logic              ready_d;
  logic              pend_d;
  logic              line_d;

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q, wptr_d, rptr_d;
  logic              push_c, pop_c, empty_c, full_d;

  assign push_c  = tx_valid & tx_ready;
  assign empty_c = (wptr_q == rptr_q);
  assign pop_c   = (state_q == IDLE) & ~empty_c;
  assign wptr_d  = wptr_q + PW'(push_c);
  assign rptr_d  = rptr_q + PW'(pop_c);
  assign full_d  = (wptr_d[PTR_W] != rptr_d[PTR_W]) &&
                   (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]);
  assign start_c = pop_c;
  assign word_c  = mem_q[rptr_q[PTR_W-1:0]];
  assign ready_d = ~full_d;
  assign pend_d  = (wptr_d != rptr_d);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_c) begin
      mem_q[wptr_q[PTR_W-1:0]] <= tx_data;
    end
  end
`else
  assign start_c = tx_valid & tx_ready;
  assign word_c  = tx_data;
  assign ready_d = (state_d == IDLE);
  assign pend_d  = 1'b0;
`endif

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .clear_i  (start_c),
    .div_i    (div_q),
    .tick_c_o (tick_c)
  );

  // Frame sequencing; bit_q indexes data bits, stop bits and gap periods.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          state_d = START;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick_c) state_d = DATA;
      end
      DATA: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(DATA_W - 1)) begin
            bit_d   = '0;
            state_d = parity_enabled(par_q) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (tick_c) state_d = STOP;
      end
      STOP: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(two_q)) begin
            bit_d   = '0;
            state_d = (GAP_BITS != 0) ? GAP : IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      GAP: begin
        if (tick_c) begin
          if (bit_q == BIT_W'(GAP_BITS - 1)) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the upcoming cycle, registered below so uart_tx is glitch-free.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = data_q[bit_d[IDX_W-1:0]];
      PARITY:  line_d = (par_q == PAR_ODD) ? ~^data_q : ^data_q;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      data_q   <= '0;
      div_q    <= '0;
      par_q    <= PAR_NONE;
      two_q    <= 1'b0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      uart_tx  <= line_d;
      busy     <= (state_d != IDLE) | pend_d;
      tx_done  <= (state_q != IDLE) && (state_d == IDLE);
      tx_ready <= ready_d;
      if (start_c) begin
        data_q <= word_c;
        div_q  <= baud_div;
        par_q  <= parity_mode;
        two_q  <= two_stop;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: vector table, hand sequences and randomized frames
// compared against a bit-list frame model.
module tb_uart_tx_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [DIV_W-1:0]  baud_div;
  logic [1:0]        parity_mode;
  logic              two_stop;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              uart_tx;
  logic              busy;
  logic              tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_bits[$];

  always #5 clock = ~clock;

  uart_tx_core #(
    .DATA_W(DATA_W), .DIV_W(DIV_W), .GAP_BITS(0), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .uart_tx(uart_tx), .busy(busy), .tx_done(tx_done)
  );

  typedef struct {
    logic [7:0]  d;
    int unsigned dv;
    logic [1:0]  pm;
    logic        ts;
    logic        exp_par;
    int unsigned exp_len;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame as a list of line levels, one per bit period.
  function automatic void build_bits(input logic [7:0] d, input logic [1:0] pm, input logic ts);
    int ones;
    ones = $countones(d);
    exp_bits = {};
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pm == 2'b01) exp_bits.push_back(bit'(ones % 2));
    if (pm == 2'b10) exp_bits.push_back(bit'(1 - ones % 2));
    exp_bits.push_back(1'b1);
    if (ts) exp_bits.push_back(1'b1);
  endfunction

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (tx_ready !== 1'b1 && i < 500) begin
      @(negedge clock);
      i++;
    end
    check({tag, " ready_wait"}, 32'(tx_ready), 1);
  endtask

  // Entered at the negedge of the first START cycle; returns at the tx_done cycle.
  task automatic check_frame(input string tag, input logic [7:0] d, input int unsigned dv,
                             input logic [1:0] pm, input logic ts,
                             output int unsigned len, output logic pbit);
    int unsigned bad;
    bad  = 0;
    len  = 0;
    pbit = 1'bx;
    build_bits(d, pm, ts);
    for (int k = 0; k < exp_bits.size(); k++) begin
      for (int unsigned c = 0; c <= dv; c++) begin
        if (uart_tx !== exp_bits[k]) bad++;
        if (tx_done !== 1'b0) bad++;
        if (busy === 1'b1) len++;
        if (k == 9 && c == 0) pbit = uart_tx;
        @(negedge clock);
      end
    end
    check({tag, " line"}, bad, 0);
    check({tag, " done"}, 32'(tx_done), 1);
    check({tag, " busy_end"}, 32'(busy), 0);
    check({tag, " len_model"}, len, 32'(exp_bits.size()) * (dv + 1));
  endtask

  task automatic send_frame(input string tag, input logic [7:0] d, input int unsigned dv,
                            input logic [1:0] pm, input logic ts,
                            output int unsigned len, output logic pbit);
    tx_data     = d;
    baud_div    = DIV_W'(dv);
    parity_mode = pm;
    two_stop    = ts;
    tx_valid    = 1'b1;
    wait_ready(tag);
    @(posedge clock);
    @(negedge clock);
    // Disturb every sampled input mid-frame; the frame must not change.
    tx_valid    = 1'b0;
    tx_data     = 8'($urandom);
    baud_div    = DIV_W'(dv + 6);
    parity_mode = 2'($urandom);
    two_stop    = 1'($urandom);
    check_frame(tag, d, dv, pm, ts, len, pbit);
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic fifo_test();
    logic [7:0] w [5];
    logic [7:0] got;
    logic       rdy;
    int         acc, to_p, to_d;
    w = '{8'h3A, 8'hC5, 8'h0F, 8'hF0, 8'h99};
    baud_div = DIV_W'(1); parity_mode = 2'b00; two_stop = 1'b0;
    fork
      begin
        acc = 0; to_p = 0;
        while (acc < 5 && to_p < 200) begin
          tx_data = w[acc]; tx_valid = 1'b1; rdy = tx_ready;
          @(posedge clock);
          if (rdy) acc++;
          @(negedge clock);
          to_p++;
        end
        tx_valid = 1'b0;
        check("fifo ready_low", 32'(tx_ready), 0);
      end
      begin
        for (int f = 0; f < 5; f++) begin
          to_d = 0;
          while (uart_tx !== 1'b0 && to_d < 400) begin
            @(negedge clock);
            to_d++;
          end
          got = '0;
          for (int b = 0; b < 8; b++) begin
            repeat (2) @(negedge clock);
            got[b] = uart_tx;
          end
          repeat (2) @(negedge clock);
          check("fifo word", 32'(got), 32'(w[f]));
        end
      end
    join
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs [7];
    int unsigned len;
    logic        pbit;
    int          hits;
    logic [7:0]  rd;
    int unsigned rdv;
    logic [1:0]  rpm;
    logic        rts;

    vecs[0] = '{8'hA5, 3, 2'b01, 1'b0, 1'b0, 44};
    vecs[1] = '{8'h07, 0, 2'b10, 1'b1, 1'b0, 12};
    vecs[2] = '{8'hFF, 1, 2'b10, 1'b0, 1'b1, 22};
    vecs[3] = '{8'h00, 2, 2'b00, 1'b1, 1'b0, 33};
    vecs[4] = '{8'h80, 0, 2'b11, 1'b0, 1'b0, 10};
    vecs[5] = '{8'h01, 4, 2'b01, 1'b1, 1'b1, 60};
    vecs[6] = '{8'h3C, 9, 2'b10, 1'b0, 1'b1, 110};

    reset_n = 1'b0; tx_valid = 1'b0; tx_data = '0; baud_div = '0;
    parity_mode = 2'b00; two_stop = 1'b0;
    repeat (3) @(negedge clock);
    check("reset uart_tx", 32'(uart_tx), 1);
    check("reset busy", 32'(busy), 0);
    check("reset ready", 32'(tx_ready), 0);
    check("reset done", 32'(tx_done), 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("release ready", 32'(tx_ready), 1);

`ifdef UART_TX_FIFO_EN
    fifo_test();
`else
    for (int v = 0; v < 7; v++) begin
      send_frame($sformatf("vec%0d", v), vecs[v].d, vecs[v].dv, vecs[v].pm, vecs[v].ts, len, pbit);
      check($sformatf("vec%0d len", v), len, vecs[v].exp_len);
      if (vecs[v].pm == 2'b01 || vecs[v].pm == 2'b10)
        check($sformatf("vec%0d parity", v), 32'(pbit), 32'(vecs[v].exp_par));
    end

    // Back-to-back: valid held across the tx_done cycle.
    tx_data = 8'h11; baud_div = DIV_W'(1); parity_mode = 2'b00; two_stop = 1'b0;
    tx_valid = 1'b1;
    wait_ready("b2b");
    @(posedge clock);
    @(negedge clock);
    tx_data = 8'h22;
    check_frame("b2b0", 8'h11, 1, 2'b00, 1'b0, len, pbit);
    check("b2b ready_at_done", 32'(tx_ready), 1);
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    check_frame("b2b1", 8'h22, 1, 2'b00, 1'b0, len, pbit);

    // Reset during data bit 3 of 0xA5 (a low bit).
    tx_data = 8'hA5; baud_div = DIV_W'(3); parity_mode = 2'b01; two_stop = 1'b0;
    tx_valid = 1'b1;
    wait_ready("rst");
    @(posedge clock);
    @(negedge clock);
    tx_valid = 1'b0;
    repeat (17) @(negedge clock);
    check("rst pre line", 32'(uart_tx), 0);
    check("rst pre busy", 32'(busy), 1);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("rst line", 32'(uart_tx), 1);
    check("rst busy", 32'(busy), 0);
    check("rst ready", 32'(tx_ready), 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("rst release ready", 32'(tx_ready), 1);
    hits = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx_done !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0) hits++;
      @(negedge clock);
    end
    check("rst quiet after abort", hits, 0);

    for (int r = 0; r < 20; r++) begin
      rd  = 8'($urandom);
      rdv = $urandom_range(0, 4);
      rpm = 2'($urandom);
      rts = 1'($urandom);
      send_frame($sformatf("rnd%0d", r), rd, rdv, rpm, rts, len, pbit);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- Parametrised UART transmitter; successor to the fixed 8-bit, derived-clock UART TX in the subsystem.
- Runs entirely in the system `clock` domain and uses a baud-tick enable, not a generated clock.
- Supports configurable data width, parity mode, stop-bit count and inter-frame gap.
- Uses a valid/ready handshake. Sits between the register/CPU interface and the pad `uart_tx`.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- DIV_W, 16, width of the baud divisor.
- GAP_BITS, 0, idle bit periods forced after each stop phase; legal 0..255.
- FIFO_DEPTH, 8, TX FIFO entries; power of two; used only with UART_TX_FIFO_EN.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- baud_div  in  DIV_W  bit period = baud_div+1 clocks; sampled at frame start
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  0 = one stop bit, 1 = two stop bits
- tx_data  in  DATA_W  word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  block can accept a word this cycle
- uart_tx  out  1  serial line, idle high
- busy  out  1  a frame (including its gap) is in progress
- tx_done  out  1  one-cycle pulse at the end of each frame's gap/stop phase

Behaviour:
- Reset (sync, reset_n=0 at a clock edge):
  - uart_tx=1, busy=0, tx_done=0, tx_ready=0 during reset, FSM=IDLE, counters=0.
  - tx_ready=1 in the first cycle after release.
  - Reset mid-frame aborts the frame; uart_tx returns to 1 on the next edge.
- Handshake:
  - A transfer occurs when tx_valid & tx_ready are both 1 at a clock edge.
  - Without the FIFO, tx_ready = (state==IDLE).
  - tx_valid while tx_ready=0 is ignored; the source must hold it.
- Frame-start sampling: tx_data, baud_div, parity_mode and two_stop are latched into shadow registers at accept. Changes mid-frame have no effect.
- Baud tick:
  - The counter clears at accept and counts 0..div_shadow.
  - tick = (cnt==div_shadow); the counter wraps to 0 on tick.
  - baud_div=0 gives a one-clock bit period.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
  - IDLE -> START on accept. uart_tx=0 from the edge after accept (1-cycle latency).
  - START -> DATA on tick.
  - DATA: bits are driven LSB first. bit_idx advances on tick. -> PARITY when bit_idx==DATA_W-1 and tick, if parity is enabled; otherwise -> STOP.
  - PARITY: even bit = ^data; odd bit = ~^data. -> STOP on tick.
  - STOP: uart_tx=1 for 1 or 2 bit periods. On the last tick -> GAP if GAP_BITS>0, else -> IDLE.
  - GAP: uart_tx=1 for GAP_BITS bit periods -> IDLE.
- Every bit is exactly div_shadow+1 clocks long.
- Frame length = (1 + DATA_W + p + s + GAP_BITS) × (div_shadow+1) clocks, where p ∈ {0,1} is the parity bit and s ∈ {1,2} is the stop-bit count.
- tx_done pulses in the same cycle the FSM enters IDLE. busy=0 in that same cycle.
- Back-to-back frames: a word accepted in the tx_done cycle starts its START bit on the next edge, with no extra idle clock.
- uart_tx is registered (glitch-free).

Optional Feature:
- UART_TX_FIFO_EN defined:
  - A FIFO of FIFO_DEPTH×DATA_W entries sits ahead of the FSM; tx_ready = !full.
  - The FSM pops on IDLE & !empty.
  - A simultaneous push and pop while full is allowed only if the pop frees a slot this cycle; tx_ready still reflects the registered full flag.
  - Pointers wrap modulo FIFO_DEPTH, with one extra bit used to distinguish full from empty.
  - Reset empties the FIFO. busy = FSM not IDLE or FIFO not empty.
- Undefined: no FIFO, handshake exactly as in Behaviour.

Decomposition:
- Package uart_pkg holds:
  - The state localparams (IDLE..GAP).
  - The parity_mode encodings PAR_NONE/PAR_EVEN/PAR_ODD.
  - Legal-range constants for DATA_W.
- Sub-module uart_baud_gen (counter with synchronous clear, tick output) is natural and reusable by a future RX.
- The FIFO is inline, under the macro.

Test Plan:
- DATA_W=8, baud_div=3, even parity, one stop. Send 0xA5 -> uart_tx low 4 clocks, then data 1,0,1,0,0,1,0,1 (4 clocks each), parity 0, stop 1. tx_done 44 clocks after the START bit begins.
- Odd parity, two_stop=1, baud_div=0, send 0x07 -> 12 one-clock bits, parity bit=0. busy high exactly 12 cycles.
- Hold tx_valid high with 0x11 then 0x22 continuously -> second START immediately follows the tx_done cycle; no gap clocks when GAP_BITS=0.
- Change baud_div from 3 to 9 mid-frame -> the current frame keeps 4-clock bits and the next frame uses 10-clock bits.
- Assert reset_n=0 during the DATA bit 3 period -> uart_tx=1 and busy=0 on the next edge. tx_ready=1 after release; no tx_done pulse.
- With UART_TX_FIFO_EN, FIFO_DEPTH=4: push 5 words at baud_div=1 -> tx_ready drops after 5 accepts (4 queued plus 1 in flight). All 5 words transmitted in order.
